// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: blank/dash patterns,
// the active-low gfedcba glyph table and the digit-index width helper.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry n is the active-low {g,f,e,d,c,b,a} pattern for nibble value n.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic int seg_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder; in decimal mode values above 9
// render as a dash so an invalid digit can never be mistaken for an 8.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_GLYPHS[nibble_i];
    if (!hex_i && (nibble_i > 4'd9)) begin
      seg_n_o = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with a
// frame-synchronous load. Define SEG_LZB_EN for decimal leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter bit HEX_DEFAULT = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_in,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output logic                    err
);

  localparam int SLOT_W = $clog2(CLK_DIV);
  localparam int IDX_W  = seg_idx_width(NUM_DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0] slotCnt_q, slotCnt_d;
  logic [IDX_W-1:0]  digitIdx_q, digitIdx_d;
  logic              slotEnd, frameEnd;

  logic [4*NUM_DIGITS-1:0] pendValue_q, pendValue_d;
  logic [NUM_DIGITS-1:0]   pendDp_q, pendDp_d;
  logic                    pendHex_q, pendHex_d;
  logic                    pendValid_q, pendValid_d;
  logic [4*NUM_DIGITS-1:0] actValue_q, actValue_d;
  logic [NUM_DIGITS-1:0]   actDp_q, actDp_d;
  logic                    mode_q, mode_d;

  logic                    badDigit;
  logic                    err_q, err_d;
  logic                    frameDone_q, frameDone_d;
  logic [NUM_DIGITS-1:0]   lzbMask;

  logic [3:0]              curNibble;
  logic                    curDp, curBlank;
  logic [NUM_DIGITS-1:0]   anOneCold;
  logic [6:0]              decSeg;
  logic [6:0]              segN_q;
  logic                    dpN_q;
  logic [NUM_DIGITS-1:0]   anN_q;

  assign slotEnd  = (slotCnt_q == SLOT_LAST);
  assign frameEnd = slotEnd && (digitIdx_q == IDX_LAST);

  always_comb begin
    slotCnt_d  = slotEnd ? '0 : slotCnt_q + SLOT_W'(1);
    digitIdx_d = digitIdx_q;
    if (slotEnd) begin
      digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + IDX_W'(1);
    end
  end

  // frame_done is registered from next state so it is high during the
  // final cycle of the last slot, the same cycle the buffers swap.
  assign frameDone_d = (slotCnt_d == SLOT_LAST) && (digitIdx_d == IDX_LAST);

  always_comb begin
    pendValue_d = pendValue_q;
    pendDp_d    = pendDp_q;
    pendHex_d   = pendHex_q;
    pendValid_d = pendValid_q;
    actValue_d  = actValue_q;
    actDp_d     = actDp_q;
    mode_d      = mode_q;
    if (frameEnd && pendValid_q) begin
      actValue_d  = pendValue_q;
      actDp_d     = pendDp_q;
      mode_d      = pendHex_q;
      pendValid_d = 1'b0;
    end
    if (load) begin
      pendValue_d = value_in;
      pendDp_d    = dp_in;
      pendHex_d   = hex_in;
      pendValid_d = 1'b1;
    end
  end

  always_comb begin
    badDigit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (actValue_d[4*k +: 4] > 4'd9) begin
        badDigit = 1'b1;
      end
    end
    err_d = err_q;
    if (frameEnd) begin
      err_d = !mode_d && badDigit;
    end
  end

`ifdef SEG_LZB_EN
  logic [NUM_DIGITS-1:0] lzbMask_q, lzbMask_d;
  logic                  upperZero;

  // Walk from the top digit down; a digit blanks while everything above it is zero.
  always_comb begin
    lzbMask_d = lzbMask_q;
    upperZero = 1'b1;
    if (frameEnd) begin
      lzbMask_d = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        upperZero    = upperZero && (actValue_d[4*k +: 4] == 4'd0);
        lzbMask_d[k] = upperZero && !mode_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lzbMask_q <= '0;
    end else begin
      lzbMask_q <= lzbMask_d;
    end
  end

  assign lzbMask = lzbMask_q;
`else
  assign lzbMask = '0;
`endif

  always_comb begin
    curNibble = 4'd0;
    curDp     = 1'b0;
    curBlank  = 1'b0;
    anOneCold = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digitIdx_q == IDX_W'(k)) begin
        curNibble    = actValue_q[4*k +: 4];
        curDp        = actDp_q[k];
        curBlank     = lzbMask[k];
        anOneCold[k] = 1'b0;
      end
    end
  end

  seg_hex_decode u_decode (
    .nibble_i (curNibble),
    .hex_i    (mode_q),
    .seg_n_o  (decSeg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slotCnt_q   <= '0;
      digitIdx_q  <= '0;
      pendValue_q <= '0;
      pendDp_q    <= '0;
      pendHex_q   <= 1'b0;
      pendValid_q <= 1'b0;
      actValue_q  <= '0;
      actDp_q     <= '0;
      mode_q      <= HEX_DEFAULT;
      err_q       <= 1'b0;
      frameDone_q <= 1'b0;
      segN_q      <= SEG_BLANK;
      dpN_q       <= 1'b1;
      anN_q       <= '1;
    end else begin
      slotCnt_q   <= slotCnt_d;
      digitIdx_q  <= digitIdx_d;
      pendValue_q <= pendValue_d;
      pendDp_q    <= pendDp_d;
      pendHex_q   <= pendHex_d;
      pendValid_q <= pendValid_d;
      actValue_q  <= actValue_d;
      actDp_q     <= actDp_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      frameDone_q <= frameDone_d;
      segN_q      <= curBlank ? SEG_BLANK : decSeg;
      dpN_q       <= ~curDp;
      anN_q       <= anOneCold;
    end
  end

  assign seg_n      = segN_q;
  assign dp_n       = dpN_q;
  assign an_n       = anN_q;
  assign frame_done = frameDone_q;
  assign err        = err_q;

endmodule
